sram_responder: RTL and testbench
=================================

# sram_responder

Memory-side responder for the SLC-3 external SRAM bus: it answers the CPU/Mem2IO strobes (active-low CE, UB, LB, OE, WE), the 20-bit address and the 16-bit bidirectional data bus. A clocked on-chip word array is the storage. Accesses are stretched by a programmable number of wait states and reported with a level `mem_ready` handshake. It replaces the off-chip SRAM in simulation and FPGA-only builds, sitting at the memory end of the pins that SLC drives.

## Interface
- `ADDR_W`, default 10: log2 of array depth in 16-bit words; valid addresses are `A < 2**ADDR_W`.
- `WAIT_CYCLES`, default 2: wait states inserted before an access completes; range 0..15.
- `Clk` in 1: the single clock; every transfer happens on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `CE` in 1: chip enable, active-low.
- `UB` in 1: upper byte enable (`Data[15:8]`), active-low.
- `LB` in 1: lower byte enable (`Data[7:0]`), active-low.
- `OE` in 1: output (read) enable, active-low.
- `WE` in 1: write enable, active-low.
- `A` in 20: word address.
- `Data` inout 16: bidirectional data bus; high-Z whenever the block is not driving it.
- `mem_ready` out 1: access complete; held high through the hold phase.
- `Err` out 1: the current completed access was out of range.

## Operation
- States: `IDLE`, `BUSY`, `HOLD`.
- Request condition: `CE`=0 and (`WE`=0 or `OE`=0). If `WE`=0 and `OE`=0 together, the access is a write.
- **IDLE, request present at an edge:**
  - Latch `A`, `UB`, `LB`, the direction and (for a write) `Data`.
  - Load the counter with `WAIT_CYCLES`.
  - Go to `BUSY`.
- **BUSY:**
  - Abort: if `CE`=1, or the originating strobe (`WE` for a write, `OE` for a read) is 1, go to `IDLE`. No array update, `mem_ready` never rises.
  - Counter not 0: decrement it.
  - Counter 0, latched address in range:
    - Write: update only the enabled bytes (`UB`=0 updates [15:8], `LB`=0 updates [7:0]).
    - Read: register the word into the read buffer; disabled lanes read as 8'h00.
    - Go to `HOLD`, `Err`=0.
  - Counter 0, latched address out of range (`A[19:ADDR_W]` ≠ 0): write ignored, read buffer = 16'h0000, go to `HOLD`, `Err`=1.
- **HOLD:**
  - `mem_ready`=1.
  - A read drives the read buffer onto `Data`; a write never drives `Data`.
  - Leave to `IDLE` at the first edge where `CE`=1 or the originating strobe = 1.
  - Strobe changes other than these (for example `WE` falling during a read hold) are ignored.
- Address, byte-enable and data changes after the latch edge have no effect on the current access.
- The array is not cleared by reset and has no defined power-up content. The bench must write before reading.

## Timing
- Reset (asynchronous, while `Reset`=0): state `IDLE`, `mem_ready`=0, `Err`=0, `Data` high-Z, counter 0, read buffer 16'h0000. A reset during `BUSY` or `HOLD` abandons the access. A write in `BUSY` is not performed.
- Let the request be sampled at edge k.
  - `BUSY` from k.
  - Array write / read-buffer load at edge k+`WAIT_CYCLES`+1.
  - `mem_ready`, `Err` and (for a read) the `Data` drive are valid after edge k+`WAIT_CYCLES`+1.
  - `WAIT_CYCLES`=0 gives a 1-cycle access.
- Release: strobe deasserted before edge m, state `IDLE` and `mem_ready`=0 after edge m. `Data` is still driven during the cycle between the strobe deassert and edge m, so the initiator must not drive `Data` in that cycle.
- Back-to-back accesses:
  - Earliest next request sample is edge m+1.
  - A request held continuously through the release is therefore impossible, because the release itself requires deassertion.
- `mem_ready` and `Err` are registered outputs. `Data` enable is decoded from the registered state and direction only.

## Test plan
- **Reset mid-access:** with `WAIT_CYCLES`=2, write 16'hBEEF to A=5 and pull `Reset` low in `BUSY`. Then read A=5 (after a prior write of 16'h1111). Required: reads 16'h1111, `mem_ready`=0 and `Data` high-Z immediately on reset.
- **Write/read latency:** write 16'h1234 to A=3, release, then read A=3. Required: `mem_ready` rises 3 cycles after each request edge, and the read returns 16'h1234 on `Data` until `OE` rises.
- **Byte lanes:** write 16'hFFFF to A=7, then write 16'hAB00 with `UB`=0, `LB`=1, then read with `UB`=1, `LB`=0. Required: array word = 16'hABFF, and the read returns 16'h00FF.
- **Out of range:** write 16'h5555 to A=20'h00400, then read A=20'h00400 and read A=0 (previously written 16'h0F0F). Required: `Err`=1 with data 16'h0000 for the first read; A=0 still reads 16'h0F0F with `Err`=0, so there is no aliasing.
- **Abort:** start a write of 16'h9999 to A=9 (prior content 16'h2222) and raise `WE` after 1 cycle of `BUSY`. Required: `mem_ready` stays 0 and a later read of A=9 returns 16'h2222.
- **Simultaneous strobes and zero wait:** with `WAIT_CYCLES`=0, assert `OE`=0 and `WE`=0 together with `Data`=16'hC0DE at A=1. Required: treated as a write, `Data` never driven by the block, `mem_ready` high 1 cycle after the request edge, and a subsequent read returns 16'hC0DE.

Source files
------------

// File: rtl/sram_responder_if.sv
// Strobe/address side of the SLC-3 SRAM bus plus the completion flags.
// The bidirectional Data bus stays a plain inout on the responder.
interface sram_responder_if;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] A;
  logic        mem_ready;
  logic        Err;

  modport master (
    output CE, UB, LB, OE, WE, A,
    input  mem_ready, Err
  );

  modport slave (
    input  CE, UB, LB, OE, WE, A,
    output mem_ready, Err
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip replacement for the SLC-3 external SRAM: latches a request, waits
// WAIT_CYCLES, performs the access and holds mem_ready until the strobe drops.
module sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus,
  inout  wire  [15:0]       Data,
  output logic [1:0]        state_o,
  output logic              data_oe_o
);

  // Handshake: a request is CE=0 with WE=0 or OE=0 (WE wins). mem_ready is a
  // level that stays high until CE or the originating strobe returns high; the
  // responder is back in IDLE one edge after that and mem_ready is low again.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic        ub_q, ub_d;
  logic        lb_q, lb_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rbuf_q, rbuf_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [15:0] mem_q [DEPTH];
  logic        mem_we;
  logic [15:0] mem_rd;
  logic [15:0] mem_wr;

  logic        req;
  logic        strobe_off;
  logic        in_range;
  logic        data_oe;

  assign req        = !bus.CE && (!bus.WE || !bus.OE);
  assign strobe_off = bus.CE || (wr_q ? bus.WE : bus.OE);
  assign in_range   = ((addr_q >> ADDR_W) == 20'd0);

  assign mem_rd = mem_q[addr_q[ADDR_W-1:0]];
  // Lanes are active-low: a disabled lane keeps the stored byte.
  assign mem_wr = {ub_q ? mem_rd[15:8] : wdata_q[15:8],
                   lb_q ? mem_rd[7:0]  : wdata_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          addr_d  = bus.A;
          ub_d    = bus.UB;
          lb_d    = bus.LB;
          wr_d    = !bus.WE;
          wdata_d = Data;
          cnt_d   = WAIT_INIT;
        end
      end
      BUSY: begin
        if (strobe_off) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = HOLD;
          err_d   = !in_range;
          if (wr_q) begin
            mem_we = in_range;
          end else if (in_range) begin
            rbuf_d = {ub_q ? 8'h00 : mem_rd[15:8], lb_q ? 8'h00 : mem_rd[7:0]};
          end else begin
            rbuf_d = 16'h0000;
          end
        end
      end
      HOLD: begin
        if (strobe_off) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == HOLD);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
      rbuf_q  <= 16'h0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset: its content is undefined until written.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[addr_q[ADDR_W-1:0]] <= mem_wr;
    end
  end

  assign data_oe       = (state_q == HOLD) && !wr_q;
  assign Data          = data_oe ? rbuf_q : 16'hzzzz;
  assign bus.mem_ready = ready_q;
  assign bus.Err       = err_q;
  assign state_o       = state_q;
  assign data_oe_o     = data_oe;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one instance with two wait states, one with none,
// checked against a lane-aware word-array model of the SRAM.
module tb_sram_responder;
  localparam int W_SLOW = 2;
  localparam int W_FAST = 0;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        ce, ub, lb, oe, we;
  logic [19:0] a;
  logic [15:0] dout;
  logic        doe;
  int          errors;
  int          checks;
  logic [15:0] ref_mem [2][1024];

  sram_responder_if bus_slow ();
  sram_responder_if bus_fast ();
  wire  [15:0] data_slow;
  wire  [15:0] data_fast;
  logic [1:0]  state_slow, state_fast;
  logic        oe_slow, oe_fast;

  assign bus_slow.CE = sel ? 1'b1 : ce;
  assign bus_slow.UB = sel ? 1'b1 : ub;
  assign bus_slow.LB = sel ? 1'b1 : lb;
  assign bus_slow.OE = sel ? 1'b1 : oe;
  assign bus_slow.WE = sel ? 1'b1 : we;
  assign bus_slow.A  = a;
  assign bus_fast.CE = sel ? ce : 1'b1;
  assign bus_fast.UB = sel ? ub : 1'b1;
  assign bus_fast.LB = sel ? lb : 1'b1;
  assign bus_fast.OE = sel ? oe : 1'b1;
  assign bus_fast.WE = sel ? we : 1'b1;
  assign bus_fast.A  = a;
  assign data_slow   = (!sel && doe) ? dout : 16'hzzzz;
  assign data_fast   = (sel && doe) ? dout : 16'hzzzz;

  sram_responder #(.ADDR_W(10), .WAIT_CYCLES(W_SLOW)) u_slow (
    .Clk(clk), .Reset(rst_n), .bus(bus_slow), .Data(data_slow),
    .state_o(state_slow), .data_oe_o(oe_slow)
  );

  sram_responder #(.ADDR_W(10), .WAIT_CYCLES(W_FAST)) u_fast (
    .Clk(clk), .Reset(rst_n), .bus(bus_fast), .Data(data_fast),
    .state_o(state_fast), .data_oe_o(oe_fast)
  );

  logic        obs_ready, obs_err, obs_oe;
  logic [1:0]  obs_state;
  logic [15:0] obs_data;
  assign obs_ready = sel ? bus_fast.mem_ready : bus_slow.mem_ready;
  assign obs_err   = sel ? bus_fast.Err : bus_slow.Err;
  assign obs_oe    = sel ? oe_fast : oe_slow;
  assign obs_state = sel ? state_fast : state_slow;
  assign obs_data  = sel ? data_fast : data_slow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat();
    return (sel ? W_FAST : W_SLOW) + 1;
  endfunction

  function automatic logic [15:0] ref_read(input logic [19:0] addr, input logic u, input logic l);
    logic [15:0] w;
    if (addr >= 20'd1024) return 16'h0000;
    w = ref_mem[sel ? 1 : 0][addr[9:0]];
    if (u) w[15:8] = 8'h00;
    if (l) w[7:0]  = 8'h00;
    return w;
  endfunction

  task automatic ref_write(input logic [19:0] addr, input logic u, input logic l, input logic [15:0] wd);
    if (addr < 20'd1024) begin
      if (!u) ref_mem[sel ? 1 : 0][addr[9:0]][15:8] = wd[15:8];
      if (!l) ref_mem[sel ? 1 : 0][addr[9:0]][7:0]  = wd[7:0];
    end
  endtask

  task automatic strobes_idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; doe = 1'b0;
  endtask

  task automatic start_req(input bit wr, input bit both, input logic [19:0] addr,
                           input logic u, input logic l, input logic [15:0] wd);
    @(negedge clk);
    ce = 1'b0; a = addr; ub = u; lb = l;
    if (wr) begin
      we = 1'b0; oe = both ? 1'b0 : 1'b1; dout = wd; doe = 1'b1;
    end else begin
      we = 1'b1; oe = 1'b0; doe = 1'b0;
    end
  endtask

  task automatic end_req();
    @(negedge clk);
    strobes_idle();
  endtask

  task automatic do_access(input bit wr, input bit both, input logic [19:0] addr,
                           input logic u, input logic l, input logic [15:0] wd,
                           output logic [15:0] rd, output logic er, output logic drv,
                           output int lat);
    start_req(wr, both, addr, u, l, wd);
    @(posedge clk);
    lat = 0; rd = 16'h0000; er = 1'b0; drv = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (obs_ready) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h: mem_ready never rose in 40 cycles", addr);
    end
    rd = obs_data; er = obs_err; drv = obs_oe;
    end_req();
    @(posedge clk); #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_state !== 2'd0) begin
      errors++;
      $display("FAIL release addr=%h: mem_ready=%b state=%0d, want 0 and IDLE", addr, obs_ready, obs_state);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++;
      if (obs_ready !== 1'b0 || obs_err !== 1'b0 || obs_oe !== 1'b0 || obs_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d: ready=%b err=%b oe=%b state=%0d, want 0/0/0/IDLE",
                 s, obs_ready, obs_err, obs_oe, obs_state);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rd; logic er, drv; int lat; bit seen;
    sel = 1'b0;
    do_access(1, 0, 20'd5, 0, 0, 16'h1111, rd, er, drv, lat);
    ref_write(20'd5, 0, 0, 16'h1111);
    start_req(1, 0, 20'd5, 0, 0, 16'hBEEF);
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (obs_state !== 2'd1) begin
      errors++; $display("FAIL rst_busy_state: state=%0d, want BUSY", obs_state);
    end
    rst_n = 1'b0; strobes_idle(); #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_oe !== 1'b0 || obs_state !== 2'd0) begin
      errors++; $display("FAIL rst_busy_clear: ready=%b oe=%b state=%0d, want 0/0/IDLE", obs_ready, obs_oe, obs_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_access(0, 0, 20'd5, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (rd !== ref_read(20'd5, 0, 0)) begin
      errors++; $display("FAIL rst_busy_no_write: read %h, want %h", rd, ref_read(20'd5, 0, 0));
    end
    start_req(0, 0, 20'd5, 0, 0, 16'h0);
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #2;
      seen = obs_ready;
    end
    checks++;
    if (!seen || obs_oe !== 1'b1) begin
      errors++; $display("FAIL rst_hold_reach: ready=%b oe=%b, want 1/1", obs_ready, obs_oe);
    end
    rst_n = 1'b0; strobes_idle(); #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_oe !== 1'b0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL rst_hold_clear: ready=%b oe=%b err=%b, want 0/0/0", obs_ready, obs_oe, obs_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic er, drv; int lat;
    sel = 1'b0;
    do_access(1, 0, 20'd3, 0, 0, 16'h1234, rd, er, drv, lat);
    ref_write(20'd3, 0, 0, 16'h1234);
    checks++;
    if (lat != exp_lat() || drv !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL wr_latency: lat=%0d drv=%b err=%b, want %0d/0/0", lat, drv, er, exp_lat());
    end
    start_req(0, 0, 20'd3, 0, 0, 16'h0);
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (obs_ready) lat = i;
    end
    checks++;
    if (lat != exp_lat()) begin
      errors++; $display("FAIL rd_latency: lat=%0d, want %0d", lat, exp_lat());
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        @(negedge clk); we = 1'b0;
      end
      checks++;
      if (obs_data !== ref_read(20'd3, 0, 0) || obs_ready !== 1'b1 || obs_oe !== 1'b1) begin
        errors++; $display("FAIL rd_hold cycle=%0d: data=%h ready=%b, want %h/1", i, obs_data, obs_ready, ref_read(20'd3, 0, 0));
      end
      @(posedge clk); #1;
    end
    end_req(); #1;
    checks++;
    if (obs_oe !== 1'b1 || obs_data !== ref_read(20'd3, 0, 0)) begin
      errors++; $display("FAIL rd_release_drive: oe=%b data=%h, want still driven", obs_oe, obs_data);
    end
    @(posedge clk); #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_oe !== 1'b0) begin
      errors++; $display("FAIL rd_release: ready=%b oe=%b, want 0/0", obs_ready, obs_oe);
    end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd; logic er, drv; int lat;
    sel = 1'b0;
    do_access(1, 0, 20'd7, 0, 0, 16'hFFFF, rd, er, drv, lat);
    ref_write(20'd7, 0, 0, 16'hFFFF);
    do_access(1, 0, 20'd7, 0, 1, 16'hAB00, rd, er, drv, lat);
    ref_write(20'd7, 0, 1, 16'hAB00);
    do_access(0, 0, 20'd7, 1, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (rd !== ref_read(20'd7, 1, 0)) begin
      errors++; $display("FAIL lane_low_read: got %h, want %h", rd, ref_read(20'd7, 1, 0));
    end
    do_access(0, 0, 20'd7, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (rd !== ref_read(20'd7, 0, 0)) begin
      errors++; $display("FAIL lane_word: got %h, want %h", rd, ref_read(20'd7, 0, 0));
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er, drv; int lat;
    sel = 1'b0;
    do_access(1, 0, 20'd0, 0, 0, 16'h0F0F, rd, er, drv, lat);
    ref_write(20'd0, 0, 0, 16'h0F0F);
    do_access(1, 0, 20'h00400, 0, 0, 16'h5555, rd, er, drv, lat);
    ref_write(20'h00400, 0, 0, 16'h5555);
    checks++;
    if (er !== 1'b1 || lat != exp_lat()) begin
      errors++; $display("FAIL oor_write: err=%b lat=%0d, want 1/%0d", er, lat, exp_lat());
    end
    do_access(0, 0, 20'h00400, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (er !== 1'b1 || rd !== ref_read(20'h00400, 0, 0)) begin
      errors++; $display("FAIL oor_read: err=%b data=%h, want 1/%h", er, rd, ref_read(20'h00400, 0, 0));
    end
    do_access(0, 0, 20'd0, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (er !== 1'b0 || rd !== ref_read(20'd0, 0, 0)) begin
      errors++; $display("FAIL oor_alias: err=%b data=%h, want 0/%h", er, rd, ref_read(20'd0, 0, 0));
    end
  endtask

  task automatic test_abort();
    logic [15:0] rd; logic er, drv; int lat; bit rose;
    sel = 1'b0;
    do_access(1, 0, 20'd9, 0, 0, 16'h2222, rd, er, drv, lat);
    ref_write(20'd9, 0, 0, 16'h2222);
    start_req(1, 0, 20'd9, 0, 0, 16'h9999);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); we = 1'b1;
    rose = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (obs_ready) rose = 1;
    end
    checks++;
    if (rose || obs_state !== 2'd0) begin
      errors++; $display("FAIL abort_ready: ready_seen=%b state=%0d, want 0/IDLE", rose, obs_state);
    end
    end_req();
    do_access(0, 0, 20'd9, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (rd !== ref_read(20'd9, 0, 0)) begin
      errors++; $display("FAIL abort_no_write: got %h, want %h", rd, ref_read(20'd9, 0, 0));
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] rd; logic er, drv; int lat;
    sel = 1'b1;
    do_access(1, 1, 20'd1, 0, 0, 16'hC0DE, rd, er, drv, lat);
    ref_write(20'd1, 0, 0, 16'hC0DE);
    checks++;
    if (lat != exp_lat() || drv !== 1'b0) begin
      errors++; $display("FAIL zw_write: lat=%0d drv=%b, want %0d/0", lat, drv, exp_lat());
    end
    do_access(0, 0, 20'd1, 0, 0, 16'h0, rd, er, drv, lat);
    checks++;
    if (lat != exp_lat() || rd !== ref_read(20'd1, 0, 0) || drv !== 1'b1) begin
      errors++; $display("FAIL zw_read: lat=%0d data=%h, want %0d/%h", lat, rd, exp_lat(), ref_read(20'd1, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, wd; logic er, drv, u, l; int lat; bit wr, both; logic [19:0] addr;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int w = 0; w < 16; w++) begin
        wd = 16'($urandom);
        do_access(1, 0, 20'(w), 0, 0, wd, rd, er, drv, lat);
        ref_write(20'(w), 0, 0, wd);
      end
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 7) == 0)
          addr = {10'($urandom_range(1, 1023)), 10'($urandom_range(0, 1023))};
        else
          addr = 20'($urandom_range(0, 15));
        wr = 1'($urandom_range(0, 1)); both = 1'($urandom_range(0, 1));
        u = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
        wd = 16'($urandom);
        do_access(wr, both, addr, u, l, wd, rd, er, drv, lat);
        checks++;
        if (lat != exp_lat() || er !== (addr >= 20'd1024) || drv !== !wr) begin
          errors++; $display("FAIL rnd_status inst=%0d addr=%h: lat=%0d err=%b drv=%b, want %0d/%b/%b",
                             s, addr, lat, er, drv, exp_lat(), addr >= 20'd1024, !wr);
        end
        if (wr) begin
          ref_write(addr, u, l, wd);
        end else begin
          checks++;
          if (rd !== ref_read(addr, u, l)) begin
            errors++; $display("FAIL rnd_read inst=%0d addr=%h: got %h, want %h", s, addr, rd, ref_read(addr, u, l));
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    sel = 1'b0; rst_n = 1'b0;
    ub = 1'b1; lb = 1'b1; a = 20'd0; dout = 16'h0000;
    strobes_idle();
    repeat (3) @(posedge clk);
    test_reset();
    test_reset_mid_access();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_abort();
    test_zero_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
